// File: rtl/trit_word_rx.sv
// rtl/trit_word_rx.sv - serial balanced-ternary word receiver, MST first, signed binary output
module trit_word_rx #(
  parameter int N_TRITS = 9,
  parameter int BW      = 16,
  parameter int CW      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_trit,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [BW-1:0] out_data,
  output logic                 out_err,
  output logic [CW-1:0]        trit_cnt
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(N_TRITS - 1);

  state_t                state;
  logic signed [BW-1:0]  acc;
  logic [CW-1:0]         cnt;
  logic                  err;

  logic signed [BW-1:0]  trit_val;
  logic                  trit_bad;
  logic signed [BW-1:0]  acc_next;
  logic                  accept;

  // 2'b11 decodes as zero weight but poisons the whole word via err
  always_comb begin
    trit_val = '0;
    trit_bad = 1'b0;
    case (in_trit)
      2'b10:   trit_val = BW'(1);
      2'b01:   trit_val = '1;
      2'b11:   trit_bad = 1'b1;
      default: trit_val = '0;
    endcase
  end

  assign acc_next = (acc <<< 1) + acc + trit_val;
  assign accept   = (state == ST_ACC) && in_valid && !flush;
  assign trit_cnt = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (flush) begin
            acc <= '0;
            cnt <= '0;
            err <= 1'b0;
          end else if (accept) begin
            if (cnt == LAST_IDX) begin
              out_data  <= acc_next;
              out_err   <= err | trit_bad;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= ST_HOLD;
              acc       <= '0;
              cnt       <= '0;
              err       <= 1'b0;
            end else begin
              acc <= acc_next;
              cnt <= cnt + CW'(1);
              err <= err | trit_bad;
            end
          end
        end
        ST_HOLD: begin
          // flush is deliberately ignored here so a finished word is never lost
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_ACC;
          end
        end
        default: begin
          state     <= ST_ACC;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trit_word_rx.sv
// tb/tb_trit_word_rx.sv - directed self-checking bench for trit_word_rx
module tb_trit_word_rx;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_trit;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               out_err;
  logic [3:0]         trit_cnt;

  int total = 0;
  int bad   = 0;

  localparam logic [17:0] W_POS  = {9{2'b10}};
  localparam logic [17:0] W_NEG  = {9{2'b01}};
  localparam logic [17:0] W_ZERO = {9{2'b00}};
  localparam logic [17:0] W_MIX  = {2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [17:0] W_BAD  = {2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

  trit_word_rx #(.N_TRITS(9), .BW(16), .CW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_trit   (in_trit),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .trit_cnt  (trit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sends the first n trits of w, MST first, one per clock
  task automatic send_trits(input logic [17:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_trit  = w[17 - 2*i -: 2];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_trit  = 2'b00;
  endtask

  task automatic release_word();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'sd0 || out_err !== 1'b0 || trit_cnt !== 4'd0) begin
      bad++;
      $display("FAIL reset: out_valid=%b in_ready=%b out_data=%0d out_err=%b trit_cnt=%0d, want 0 1 0 0 0",
               out_valid, in_ready, out_data, out_err, trit_cnt);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_word(input string name, input logic [17:0] w, input logic [15:0] exp_data, input logic exp_err);
    send_trits(w, 8);
    total++;
    if (out_valid !== 1'b0 || trit_cnt !== 4'd8) begin
      bad++;
      $display("FAIL %s_pre: out_valid=%b trit_cnt=%0d, want 0 8", name, out_valid, trit_cnt);
    end
    in_valid = 1'b1;
    in_trit  = w[1:0];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== exp_data || out_err !== exp_err || in_ready !== 1'b0 || trit_cnt !== 4'd0) begin
      bad++;
      $display("FAIL %s: out_valid=%b out_data=%0d (%h) out_err=%b in_ready=%b trit_cnt=%0d, want 1 %h %b 0 0",
               name, out_valid, out_data, out_data, out_err, in_ready, trit_cnt, exp_data, exp_err);
    end
    release_word();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b, want 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_decode();
    test_word("all_pos", W_POS, 16'd9841, 1'b0);
    test_word("all_neg", W_NEG, 16'hD98F, 1'b0);
    test_word("all_zero", W_ZERO, 16'd0, 1'b0);
    test_word("mixed", W_MIX, 16'd5833, 1'b0);
    test_word("bad_code", W_BAD, 16'd0, 1'b1);
    test_word("clean_after_bad", W_MIX, 16'd5833, 1'b0);
  endtask

  task automatic test_backpressure();
    send_trits(W_POS, 9);
    in_valid = 1'b1;
    in_trit  = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'sd9841 || in_ready !== 1'b0 || trit_cnt !== 4'd0) begin
        bad++;
        $display("FAIL stall_%0d: out_valid=%b out_data=%0d in_ready=%b trit_cnt=%0d, want 1 9841 0 0",
                 i, out_valid, out_data, in_ready, trit_cnt);
      end
    end
    release_word();
    in_valid = 1'b0;
    total++;
    if (trit_cnt !== 4'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: trit_cnt=%0d out_valid=%b, want 0 0", trit_cnt, out_valid);
    end
    test_word("after_stall", W_NEG, 16'hD98F, 1'b0);
  endtask

  task automatic test_flush();
    send_trits(W_NEG, 4);
    total++;
    if (trit_cnt !== 4'd4) begin
      bad++;
      $display("FAIL flush_partial_cnt: trit_cnt=%0d, want 4", trit_cnt);
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_trit  = 2'b10;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    total++;
    if (trit_cnt !== 4'd0) begin
      bad++;
      $display("FAIL flush_cnt: trit_cnt=%0d, want 0", trit_cnt);
    end
    test_word("after_flush", W_POS, 16'd9841, 1'b0);

    send_trits(W_MIX, 9);
    flush = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'sd5833 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL flush_in_hold: out_valid=%b out_data=%0d out_err=%b, want 1 5833 0", out_valid, out_data, out_err);
    end
    release_word();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_hold_release: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    send_trits(W_POS, 9);
    release_word();
    send_trits(W_NEG, 5);
    total++;
    if (trit_cnt !== 4'd5 || out_data !== 16'sd9841) begin
      bad++;
      $display("FAIL pre_areset: trit_cnt=%0d out_data=%0d, want 5 9841", trit_cnt, out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (trit_cnt !== 4'd0 || out_data !== 16'sd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL areset: trit_cnt=%0d out_data=%0d out_valid=%b in_ready=%b out_err=%b, want 0 0 0 1 0",
               trit_cnt, out_data, out_valid, in_ready, out_err);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (trit_cnt !== 4'd0) begin
      bad++;
      $display("FAIL areset_cnt: trit_cnt=%0d, want 0", trit_cnt);
    end
    test_word("after_areset", W_MIX, 16'd5833, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_trit   = 2'b00;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
